// File: rtl/operand_stager.sv
// operand_stager: decode-to-execute operand stage with forwarding, immediates and load-use stall; optional stall counter under OPERAND_STAGER_PERF_EN
module operand_stager #(
  parameter int WIDTH = 64,
  parameter int NFWD  = 3,
  parameter int RADDR = 5
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [31:0]           raw_instr,
  input  logic [WIDTH-1:0]      pc,
  input  logic [2:0]            src_sel,
  input  logic                  use_rs1,
  input  logic                  use_rs2,
  input  logic [RADDR-1:0]      ra1,
  input  logic [RADDR-1:0]      ra2,
  input  logic [WIDTH-1:0]      rd1,
  input  logic [WIDTH-1:0]      rd2,
  input  logic [NFWD-1:0]       fwd_regwrite,
  input  logic [NFWD-1:0]       fwd_pending,
  input  logic [NFWD*RADDR-1:0] fwd_wa,
  input  logic [NFWD*WIDTH-1:0] fwd_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [WIDTH-1:0]      srca,
  output logic [WIDTH-1:0]      srcb,
  output logic [WIDTH-1:0]      store_data
`ifdef OPERAND_STAGER_PERF_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic [WIDTH:0]   r1, r2;
  logic [WIDTH-1:0] imm_i, imm_s, imm_u, shamt, srcb_n;
  logic             hazard, take, unused_opcode;

  // Returns {pending, data}; walks oldest to youngest so the youngest match overrides
  function automatic logic [WIDTH:0] resolve(input logic [RADDR-1:0] a, input logic [WIDTH-1:0] rd);
    logic [WIDTH:0] r;
    r = {1'b0, rd};
    for (int i = NFWD - 1; i >= 0; i--)
      if (fwd_regwrite[i] && fwd_wa[i*RADDR +: RADDR] == a)
        r = {fwd_pending[i], fwd_data[i*WIDTH +: WIDTH]};
    return a == '0 ? '0 : r;
  endfunction

  // Operand resolution, immediate selection and handshake
  always_comb begin
    r1     = resolve(ra1, rd1);
    r2     = resolve(ra2, rd2);
    imm_i  = WIDTH'($signed(raw_instr[31:20]));
    imm_s  = WIDTH'($signed({raw_instr[31:25], raw_instr[11:7]}));
    imm_u  = WIDTH'($signed({raw_instr[31:12], 12'b0}));
    shamt  = WIDTH == 32 ? WIDTH'(raw_instr[24:20]) : WIDTH'(raw_instr[25:20]);
    srcb_n = src_sel == 3'd0 ? r2[WIDTH-1:0] :
             src_sel == 3'd1 ? imm_i :
             src_sel == 3'd2 ? imm_s :
             src_sel == 3'd3 ? imm_u :
             src_sel == 3'd4 ? pc + imm_u :
             src_sel == 3'd5 ? pc + WIDTH'(4) :
             src_sel == 3'd6 ? shamt : '0;
    hazard   = in_valid && ((use_rs1 && r1[WIDTH]) || (use_rs2 && r2[WIDTH]));
    in_ready = !hazard && (!out_valid || out_ready);
    take     = in_valid && in_ready;
  end

  assign unused_opcode = ^raw_instr[6:0];

  // Output register: reset beats flush beats transfer beats consume
  always_ff @(posedge clk)
    if (reset) begin
      out_valid  <= 1'b0;
      srca       <= '0;
      srcb       <= '0;
      store_data <= '0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (take) begin
      out_valid  <= 1'b1;
      srca       <= r1[WIDTH-1:0];
      srcb       <= srcb_n;
      store_data <= r2[WIDTH-1:0];
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end

`ifdef OPERAND_STAGER_PERF_EN
  // Saturating count of cycles lost to operand hazards
  always_ff @(posedge clk)
    if (reset) stall_cycles <= '0;
    else if (hazard && stall_cycles != '1) stall_cycles <= stall_cycles + 32'd1;
`endif

endmodule

// File: tb/tb_operand_stager.sv
// tb_operand_stager: directed and random checks of operand_stager against a spec-level model
module tb_operand_stager;

  logic         clk = 1'b0;
  logic         reset, flush, in_valid, in_ready, use_rs1, use_rs2, out_valid, out_ready;
  logic [31:0]  raw_instr;
  logic [63:0]  pc, rd1, rd2, srca, srcb, store_data;
  logic [2:0]   src_sel;
  logic [4:0]   ra1, ra2;
  logic [2:0]   fwd_regwrite, fwd_pending;
  logic [14:0]  fwd_wa;
  logic [191:0] fwd_data;
`ifdef OPERAND_STAGER_PERF_EN
  logic [31:0]  stall_cycles;
`endif

  int          n_checks = 0;
  int          n_fail = 0;
  logic        e_valid = 1'b0;
  logic [63:0] e_a = '0, e_b = '0, e_sd = '0;
  logic [31:0] e_stall = '0;

  always #5 clk = ~clk;

  operand_stager #(.WIDTH(64), .NFWD(3), .RADDR(5)) dut (
    .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .raw_instr(raw_instr), .pc(pc), .src_sel(src_sel), .use_rs1(use_rs1), .use_rs2(use_rs2),
    .ra1(ra1), .ra2(ra2), .rd1(rd1), .rd2(rd2), .fwd_regwrite(fwd_regwrite),
    .fwd_pending(fwd_pending), .fwd_wa(fwd_wa), .fwd_data(fwd_data), .out_valid(out_valid),
    .out_ready(out_ready), .srca(srca), .srcb(srcb), .store_data(store_data)
`ifdef OPERAND_STAGER_PERF_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [64:0] mres(input logic [4:0] a, input logic [63:0] rd);
    if (a == 5'd0) return '0;
    for (int i = 0; i < 3; i++)
      if (fwd_regwrite[i] && fwd_wa[i*5 +: 5] == a) return {fwd_pending[i], fwd_data[i*64 +: 64]};
    return {1'b0, rd};
  endfunction

  task automatic idle();
    reset = 0; flush = 0; in_valid = 0; out_ready = 1; raw_instr = '0; pc = '0; src_sel = 3'd7;
    use_rs1 = 0; use_rs2 = 0; ra1 = '0; ra2 = '0; rd1 = '0; rd2 = '0;
    fwd_regwrite = '0; fwd_pending = '0; fwd_wa = '0; fwd_data = '0;
  endtask

  task automatic cycle(input string tag);
    logic [64:0] r1, r2;
    logic        haz, rdy;
    longint      sx, imm_i, imm_s, imm_u;
    logic [63:0] b;
    #1;
    r1 = mres(ra1, rd1);
    r2 = mres(ra2, rd2);
    haz = in_valid && ((use_rs1 && r1[64]) || (use_rs2 && r2[64]));
    rdy = !haz && (!e_valid || out_ready);
    if (!reset) chk({tag, ".in_ready"}, {63'd0, in_ready}, {63'd0, rdy});
    sx = longint'($signed(raw_instr));
    imm_i = sx >>> 20;
    imm_s = ((sx >>> 25) << 5) | longint'((raw_instr >> 7) & 32'd31);
    imm_u = longint'($signed(raw_instr & 32'hFFFF_F000));
    case (src_sel)
      3'd0: b = r2[63:0];
      3'd1: b = imm_i;
      3'd2: b = imm_s;
      3'd3: b = imm_u;
      3'd4: b = pc + imm_u;
      3'd5: b = pc + 64'd4;
      3'd6: b = {58'd0, raw_instr[25:20]};
      default: b = '0;
    endcase
    @(posedge clk);
    if (reset) begin
      e_valid = 0; e_a = '0; e_b = '0; e_sd = '0; e_stall = '0;
    end else begin
      if (haz && e_stall != 32'hFFFF_FFFF) e_stall++;
      if (flush) e_valid = 0;
      else if (in_valid && rdy) begin
        e_valid = 1; e_a = r1[63:0]; e_b = b; e_sd = r2[63:0];
      end else if (out_ready) e_valid = 0;
    end
    #1;
    chk({tag, ".out_valid"}, {63'd0, out_valid}, {63'd0, e_valid});
    chk({tag, ".srca"}, srca, e_a);
    chk({tag, ".srcb"}, srcb, e_b);
    chk({tag, ".store_data"}, store_data, e_sd);
`ifdef OPERAND_STAGER_PERF_EN
    chk({tag, ".stall_cycles"}, {32'd0, stall_cycles}, {32'd0, e_stall});
`endif
  endtask

  initial begin
    idle();
    reset = 1; in_valid = 1; src_sel = 3'd5; pc = 64'h1234;
    cycle("reset");
    chk("reset_valid_const", {63'd0, out_valid}, 64'd0);
    idle();
    in_valid = 1; use_rs2 = 1; src_sel = 3'd0; ra2 = 5'd5; rd2 = 64'hDEAD;
    fwd_regwrite = 3'b111; fwd_wa = {5'd5, 5'd5, 5'd5}; fwd_data = {64'hC, 64'hB, 64'hA};
    cycle("fwd_prio");
    chk("fwd_prio_const", srcb, 64'hA);
    ra2 = 5'd0;
    cycle("fwd_zero");
    chk("fwd_zero_const", srcb, 64'd0);
    idle();
    in_valid = 1; src_sel = 3'd1; raw_instr = 32'hFFF0_0093;
    cycle("imm_i");
    chk("imm_i_const", srcb, 64'hFFFF_FFFF_FFFF_FFFF);
    src_sel = 3'd4; raw_instr = 32'h0000_1017; pc = 64'h8000_0000;
    cycle("auipc");
    chk("auipc_const", srcb, 64'h8000_1000);
    src_sel = 3'd5;
    cycle("link");
    chk("link_const", srcb, 64'h8000_0004);
    src_sel = 3'd2; raw_instr = 32'hFE11_2FA3;
    cycle("imm_s");
    src_sel = 3'd6; raw_instr = 32'h03F0_0013;
    cycle("shamt");
    idle();
    in_valid = 1; use_rs1 = 1; ra1 = 5'd7; rd1 = 64'h1111; src_sel = 3'd7;
    fwd_regwrite = 3'b011; fwd_wa = {5'd0, 5'd7, 5'd7}; fwd_pending = 3'b001;
    fwd_data = {64'h0, 64'h2222, 64'h7777};
    cycle("stall1");
    cycle("stall2");
    fwd_pending = 3'b000;
    cycle("stall_release");
    chk("load_use_srca_const", srca, 64'h7777);
`ifdef OPERAND_STAGER_PERF_EN
    chk("stall_count_const", {32'd0, stall_cycles}, 64'd2);
`endif
    idle();
    in_valid = 1; use_rs1 = 1; ra1 = 5'd3; rd1 = 64'hAAAA; src_sel = 3'd5; pc = 64'h100;
    cycle("bp_load");
    out_ready = 0; rd1 = 64'hBBBB; pc = 64'h200;
    for (int k = 0; k < 3; k++) cycle("bp_hold");
    out_ready = 1;
    cycle("bp_release");
    chk("bp_release_const", srca, 64'hBBBB);
    flush = 1; rd1 = 64'hCCCC;
    cycle("flush");
    flush = 0;
    fwd_regwrite = 3'b001; fwd_wa = {5'd0, 5'd0, 5'd3}; fwd_pending = 3'b001;
    cycle("pre_reset_stall");
    reset = 1;
    cycle("reset_mid_stall");
    reset = 0; fwd_pending = 3'b000;
    cycle("after_reset");
    for (int k = 0; k < 400; k++) begin
      reset = $urandom_range(0, 63) == 0;
      flush = $urandom_range(0, 15) == 0;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 3) != 0;
      raw_instr = $urandom;
      pc = {$urandom, $urandom};
      src_sel = 3'($urandom_range(0, 7));
      use_rs1 = $urandom_range(0, 1) == 1;
      use_rs2 = $urandom_range(0, 1) == 1;
      ra1 = 5'($urandom_range(0, 3));
      ra2 = 5'($urandom_range(0, 3));
      rd1 = {$urandom, $urandom};
      rd2 = {$urandom, $urandom};
      fwd_regwrite = 3'($urandom_range(0, 7));
      for (int i = 0; i < 3; i++) begin
        fwd_pending[i] = $urandom_range(0, 3) == 0;
        fwd_wa[i*5 +: 5] = 5'($urandom_range(0, 3));
        fwd_data[i*64 +: 64] = {$urandom, $urandom};
      end
      cycle("rnd");
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
